// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entry and exit lanes: round-robin arbitration, password check, open/clear sequencing, occupancy.
// Latency: entry opens 1 cycle after grant (CHECK); exit opens on the grant edge. Lanes are held off outside IDLE; all outputs are registered-state decodes.
module parking_gate_arbiter #(
  parameter int         CAPACITY    = 8,
  parameter int         OPEN_CYCLES = 4,
  parameter logic [1:0] PW1         = 2'b01,
  parameter logic [1:0] PW2         = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entrance_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] password_user1,
  input  logic [1:0] password_user2,
  output logic       gate_open,
  output logic       green_light,
  output logic       red_light,
  output logic       grant_entry,
  output logic       grant_exit,
  output logic [3:0] occupancy,
  output logic       full
);

  typedef enum logic [2:0] {
    IDLE, CHECK, WRONG_PW, FULL_DENY, ENTRY_OPEN, EXIT_OPEN, CLEAR
  } state_t;

  localparam logic [3:0] CAP       = 4'(CAPACITY);
  localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       owner_exit;
  logic       last_exit;
  logic       cnt_load, cnt_dec, occ_inc, occ_dec, grant, win_exit;
  logic       exit_elig, pw_ok;

  assign exit_elig = exit_sensor && (occupancy != 4'd0);
  assign pw_ok     = (password_user1 == PW1) && (password_user2 == PW2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      occupancy  <= 4'd0;
      full       <= 1'b0;
      owner_exit <= 1'b0;
      last_exit  <= 1'b1;  // pretend exit won last so entry is favoured first
    end else begin
      state <= state_nxt;
      if (cnt_load)
        cnt <= OPEN_LOAD;
      else if (cnt_dec)
        cnt <= cnt - 8'd1;
      if (grant) begin
        owner_exit <= win_exit;
        last_exit  <= win_exit;
      end
      if (occ_inc && occupancy != CAP) begin
        occupancy <= occupancy + 4'd1;
        full      <= (occupancy + 4'd1) == CAP;
      end else if (occ_dec && occupancy != 4'd0) begin
        occupancy <= occupancy - 4'd1;
        full      <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    occ_inc   = 1'b0;
    occ_dec   = 1'b0;
    grant     = 1'b0;
    win_exit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (entrance_sensor || exit_elig) begin
          grant    = 1'b1;
          win_exit = (entrance_sensor && exit_elig) ? ~last_exit : exit_elig;
          if (win_exit) begin
            state_nxt = EXIT_OPEN;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = full ? FULL_DENY : CHECK;
          end
        end
      end
      CHECK, WRONG_PW: begin
        if (pw_ok) begin
          state_nxt = ENTRY_OPEN;
          cnt_load  = 1'b1;
        end else if (state == CHECK) begin
          state_nxt = WRONG_PW;
        end else if (!entrance_sensor) begin
          state_nxt = IDLE;
        end
      end
      FULL_DENY: begin
        if (!entrance_sensor)
          state_nxt = IDLE;
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (cnt == 8'd0) begin
          state_nxt = CLEAR;
          occ_inc   = (state == ENTRY_OPEN);
          occ_dec   = (state == EXIT_OPEN);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CLEAR: begin
        if (owner_exit ? !exit_sensor : !entrance_sensor)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gate_open   = (state == ENTRY_OPEN) || (state == EXIT_OPEN);
    green_light = gate_open;
    red_light   = (state == WRONG_PW) || (state == FULL_DENY);
    grant_entry = (state == CHECK) || (state == WRONG_PW) || (state == FULL_DENY) ||
                  (state == ENTRY_OPEN) || ((state == CLEAR) && !owner_exit);
    grant_exit  = (state == EXIT_OPEN) || ((state == CLEAR) && owner_exit);
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with CAPACITY=2, OPEN_CYCLES=4.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       entrance_sensor, exit_sensor;
  logic [1:0] password_user1, password_user2;
  logic       gate_open, green_light, red_light, grant_entry, grant_exit, full;
  logic [3:0] occupancy;

  int checks = 0;
  int errors = 0;

  parking_gate_arbiter #(.CAPACITY(2), .OPEN_CYCLES(4), .PW1(2'b01), .PW2(2'b10)) dut (
    .clk(clk), .reset(reset),
    .entrance_sensor(entrance_sensor), .exit_sensor(exit_sensor),
    .password_user1(password_user1), .password_user2(password_user2),
    .gate_open(gate_open), .green_light(green_light), .red_light(red_light),
    .grant_entry(grant_entry), .grant_exit(grant_exit),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, sample 1 time unit later; grants must stay exclusive
  task automatic step();
    @(posedge clk);
    #1;
    chk("grant_mutex", {7'd0, grant_entry & grant_exit}, 8'd0);
  endtask

  task automatic chk_lights(input string tag, input logic g, input logic gr, input logic r);
    chk({tag, "_gate"}, {7'd0, gate_open}, {7'd0, g});
    chk({tag, "_green"}, {7'd0, green_light}, {7'd0, gr});
    chk({tag, "_red"}, {7'd0, red_light}, {7'd0, r});
  endtask

  initial begin
    reset = 1'b0;
    entrance_sensor = 1'b0;
    exit_sensor = 1'b0;
    password_user1 = 2'b01;
    password_user2 = 2'b10;
    #50;
    chk_lights("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_gent", {7'd0, grant_entry}, 8'd0);
    chk("rst_gext", {7'd0, grant_exit}, 8'd0);
    chk("rst_occ", {4'd0, occupancy}, 8'd0);
    chk("rst_full", {7'd0, full}, 8'd0);
    reset = 1'b1;
    step();

    // empty lot: exit request must be ignored
    exit_sensor = 1'b1;
    step();
    step();
    chk("empty_gext", {7'd0, grant_exit}, 8'd0);
    chk("empty_gate", {7'd0, gate_open}, 8'd0);
    chk("empty_occ", {4'd0, occupancy}, 8'd0);
    exit_sensor = 1'b0;
    step();

    // valid entry: CHECK at E, open E+1..E+4, CLEAR with occupancy 1 at E+5
    entrance_sensor = 1'b1;
    step();
    chk("e1_check_gent", {7'd0, grant_entry}, 8'd1);
    chk_lights("e1_check", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_lights("e1_open", 1'b1, 1'b1, 1'b0);
      chk("e1_open_occ", {4'd0, occupancy}, 8'd0);
    end
    step();
    chk_lights("e1_clear", 1'b0, 1'b0, 1'b0);
    chk("e1_clear_occ", {4'd0, occupancy}, 8'd1);
    chk("e1_clear_gent", {7'd0, grant_entry}, 8'd1);
    entrance_sensor = 1'b0;
    step();
    chk("e1_idle_gent", {7'd0, grant_entry}, 8'd0);

    // wrong password held, then corrected
    password_user2 = 2'b11;
    entrance_sensor = 1'b1;
    step();
    chk_lights("wp_check", 1'b0, 1'b0, 1'b0);
    step();
    chk_lights("wp_wrong", 1'b0, 1'b0, 1'b1);
    step();
    chk_lights("wp_wrong2", 1'b0, 1'b0, 1'b1);
    chk("wp_occ", {4'd0, occupancy}, 8'd1);
    password_user2 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_lights("wp_open", 1'b1, 1'b1, 1'b0);
    end
    step();
    chk("wp_occ2", {4'd0, occupancy}, 8'd2);
    chk("wp_full", {7'd0, full}, 8'd1);
    entrance_sensor = 1'b0;
    step();

    // full lot denies a valid entry
    entrance_sensor = 1'b1;
    step();
    chk_lights("fd", 1'b0, 1'b0, 1'b1);
    chk("fd_gent", {7'd0, grant_entry}, 8'd1);
    step();
    chk_lights("fd2", 1'b0, 1'b0, 1'b1);
    entrance_sensor = 1'b0;
    step();
    chk_lights("fd_idle", 1'b0, 1'b0, 1'b0);
    chk("fd_occ", {4'd0, occupancy}, 8'd2);

    // exit: open from the grant edge, decrement 4 edges later
    exit_sensor = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_lights("x_open", 1'b1, 1'b1, 1'b0);
      chk("x_gext", {7'd0, grant_exit}, 8'd1);
    end
    step();
    chk("x_occ", {4'd0, occupancy}, 8'd1);
    chk("x_full", {7'd0, full}, 8'd0);
    chk("x_clear_gext", {7'd0, grant_exit}, 8'd1);
    exit_sensor = 1'b0;
    step();

    // simultaneous: exit won last, so entry goes first, exit waits for IDLE
    entrance_sensor = 1'b1;
    exit_sensor = 1'b1;
    step();
    chk("sim_gent", {7'd0, grant_entry}, 8'd1);
    chk("sim_gext", {7'd0, grant_exit}, 8'd0);
    for (int i = 0; i < 5; i++) step();
    chk("sim_occ_a", {4'd0, occupancy}, 8'd2);
    step();
    chk("sim_hold_gext", {7'd0, grant_exit}, 8'd0);
    chk("sim_hold_gent", {7'd0, grant_entry}, 8'd1);
    entrance_sensor = 1'b0;
    step();
    chk("sim_idle_gent", {7'd0, grant_entry}, 8'd0);
    step();
    chk("sim_x_gext", {7'd0, grant_exit}, 8'd1);
    chk_lights("sim_x", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("sim_occ_b", {4'd0, occupancy}, 8'd1);
    exit_sensor = 1'b0;
    step();

    // async reset in the middle of ENTRY_OPEN
    entrance_sensor = 1'b1;
    step();
    step();
    step();
    chk("ar_pre_gate", {7'd0, gate_open}, 8'd1);
    #3;
    reset = 1'b0;
    #1;
    chk_lights("ar", 1'b0, 1'b0, 1'b0);
    chk("ar_gent", {7'd0, grant_entry}, 8'd0);
    chk("ar_occ", {4'd0, occupancy}, 8'd0);
    entrance_sensor = 1'b0;
    #1;
    reset = 1'b1;
    step();
    chk("ar_idle_gent", {7'd0, grant_entry}, 8'd0);
    chk("ar_idle_gate", {7'd0, gate_open}, 8'd0);
    chk("ar_idle_occ", {4'd0, occupancy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Controller that shares the single barrier gate of the car park between the entrance lane and the exit lane. It arbitrates simultaneous requests, validates the two-part entry password, sequences gate open and clear phases, and tracks occupancy against capacity. It sits between the lane sensors / keypad and the gate actuator and lights, and supplies the occupancy count to the display logic.

## Interface
- CAPACITY, 8: number of bays; legal range 1..15.
- OPEN_CYCLES, 4: clock cycles the gate is held open per grant; legal range 1..255.
- PW1, 2'b01: required value on password_user1.
- PW2, 2'b10: required value on password_user2.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- entrance_sensor  in  1  level request from the entry lane.
- exit_sensor  in  1  level request from the exit lane.
- password_user1  in  2  first password field, sampled in CHECK and WRONG_PW.
- password_user2  in  2  second password field, sampled in CHECK and WRONG_PW.
- gate_open  out  1  drive barrier open.
- green_light  out  1  passage permitted.
- red_light  out  1  wrong password or lot full at entry.
- grant_entry  out  1  entry lane currently owns the gate.
- grant_exit  out  1  exit lane currently owns the gate.
- occupancy  out  4  cars inside, 0..CAPACITY.
- full  out  1  occupancy == CAPACITY.

## Operation
- States: IDLE, CHECK, WRONG_PW, FULL_DENY, ENTRY_OPEN, EXIT_OPEN, CLEAR.
- All outputs are decoded from registered state, occupancy and counter only. Outputs do not combinationally depend on inputs.
- Output decode:
  - gate_open=1 in ENTRY_OPEN and EXIT_OPEN.
  - green_light=1 in ENTRY_OPEN and EXIT_OPEN.
  - red_light=1 in WRONG_PW and FULL_DENY.
  - grant_entry=1 in CHECK, WRONG_PW, FULL_DENY, ENTRY_OPEN, and in CLEAR when the owner is entry.
  - grant_exit=1 in EXIT_OPEN, and in CLEAR when the owner is exit.
- IDLE arbitration:
  - An exit request is eligible only when occupancy>0. An entry request is always eligible.
  - With one eligible request, that lane wins.
  - With both eligible, the winner is the lane opposite to the last winner (a 1-bit round-robin pointer, reset to favour entry). The pointer updates on every grant.
  - An entry winner goes to FULL_DENY if full, else to CHECK. An exit winner goes to EXIT_OPEN.
- CHECK: if both password fields match PW1 and PW2, go to ENTRY_OPEN; otherwise go to WRONG_PW.
- WRONG_PW: re-checks the password every cycle.
  - On a match, go to ENTRY_OPEN.
  - If entrance_sensor is 0 and there is no match, go to IDLE.
- FULL_DENY: stays until entrance_sensor=0, then goes to IDLE. If an exit completes elsewhere, the lot is not re-evaluated; the car must re-request.
- ENTRY_OPEN / EXIT_OPEN:
  - A down-counter is loaded with OPEN_CYCLES-1 on entry to the state. The state is left when the counter is 0.
  - On leaving, occupancy is incremented (entry) or decremented (exit), then the state goes to CLEAR.
  - Occupancy saturates at CAPACITY and 0; it never wraps.
- CLEAR: gate closed. Waits until the owning lane's sensor is 0, then goes to IDLE. The other lane's request is held off until IDLE.
- Reset mid-operation: the gate closes at once and occupancy returns to 0. Occupancy is not preserved across reset.

## Timing
- Reset values: state IDLE; gate_open, green_light, red_light, grant_entry, grant_exit = 0; occupancy=0; full=0; counter=0; round-robin pointer favours entry.
- Entry with correct password, request seen at edge E:
  - CHECK from E.
  - ENTRY_OPEN from E+1, with gate_open high for exactly OPEN_CYCLES cycles (E+1..E+OPEN_CYCLES).
  - occupancy updates at edge E+1+OPEN_CYCLES, the same edge that enters CLEAR.
- Exit, request seen at edge E:
  - EXIT_OPEN from E, with gate_open high for OPEN_CYCLES cycles.
  - occupancy decrements at E+OPEN_CYCLES.
- Wrong password: red_light is high from E+1. A corrected password seen at edge W opens the gate from W.
- Minimum IDLE dwell between grants is 1 cycle, since CLEAR to IDLE takes one edge.
- full is registered together with occupancy, in the same cycle.

## Test plan
- Reset then entry: reset low 50 ns, release; entrance_sensor=1, passwords 01/10. gate_open high 4 cycles starting 2 edges after the request; occupancy 0→1; green high during the open window; red never high.
- Wrong then corrected password: passwords 01/11 with entrance_sensor held. red_light high from CHECK+1, gate stays closed, occupancy unchanged. Switch to 01/10: the gate opens next cycle and occupancy +1.
- Simultaneous requests with occupancy=1: both sensors rise on the same edge.
  - The lane that did not win last gets grant first, then CLEAR, then the other lane after the first sensor drops.
  - Final occupancy is 1.
  - grant_entry and grant_exit are never both high.
- Full lot, CAPACITY=2: two valid entries take occupancy to 2 and full=1. A third entry with a correct password goes to FULL_DENY (red=1, gate 0). An exit then gives occupancy 1, full=0.
- Empty exit: occupancy=0 with exit_sensor=1. Stays IDLE, no grant, occupancy stays 0 (no underflow).
- Async reset in ENTRY_OPEN: assert reset mid-window, between clock edges. gate_open, green_light and grant_entry fall immediately; occupancy=0; IDLE after release.
